neuron_seq_ctrl: RTL and testbench

//   Parametrised control sequencer for the neural-engine datapath. Loads DEPTH input words,

---
 rtl/neuron_pkg.sv | 21 ++
 rtl/ne_wrap_counter.sv | 39 +++
 rtl/neuron_seq_ctrl.sv | 99 +++++++++
 tb/tb_neuron_seq_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and default sizing for the neuron sequencer
package neuron_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_THRESH  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_OUTPUT  = 3'd5
    } state_t;

    localparam int DEF_DEPTH     = 64;
    localparam int DEF_N_NEURONS = 4;
    localparam int DEF_ACC_PIPE  = 2;

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/ne_wrap_counter.sv
// rtl/ne_wrap_counter.sv - up counter 0..MAX with enable, synchronous clear and terminal flag
module ne_wrap_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         term
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        term  = (cnt_q == MAX_V);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = term ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/neuron_seq_ctrl.sv
// rtl/neuron_seq_ctrl.sv - load / threshold / compute / drain / output sequencer for the neural engine
module neuron_seq_ctrl
    import neuron_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int ACC_PIPE  = DEF_ACC_PIPE,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int NIDX_W   = max1($clog2(N_NEURONS))
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              chip_sel,
    input  logic              wr_en,
    input  logic              threshold_ready,
    input  logic              out_ready,
    output logic              rst_mem,
    output logic              mul_mem_en,
    output logic              ac_mem_en,
    output logic [PTR_W-1:0]  wr_data_ptr,
    output logic [PTR_W-1:0]  rd_data_ptr,
    output logic [NIDX_W-1:0] neuron_idx,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int DRAIN_MAX = (ACC_PIPE > 0) ? ACC_PIPE - 1 : 0;

    state_t state_q;
    state_t state_d;

    logic       abort;
    logic       wr_inc, rd_inc, drain_inc, nidx_inc;
    logic       wr_term, rd_term, drain_term, nidx_term;
    logic [3:0] unused_drain_cnt;

    ne_wrap_counter #(.MAX(DEPTH - 1), .W(PTR_W)) u_wr_ptr (
        .clk(clk), .rst_n(rst_n), .en(wr_inc), .clr(abort),
        .cnt(wr_data_ptr), .term(wr_term)
    );

    ne_wrap_counter #(.MAX(DEPTH - 1), .W(PTR_W)) u_rd_ptr (
        .clk(clk), .rst_n(rst_n), .en(rd_inc), .clr(abort),
        .cnt(rd_data_ptr), .term(rd_term)
    );

    ne_wrap_counter #(.MAX(DRAIN_MAX), .W(4)) u_drain (
        .clk(clk), .rst_n(rst_n), .en(drain_inc), .clr(abort),
        .cnt(unused_drain_cnt), .term(drain_term)
    );

    ne_wrap_counter #(.MAX(N_NEURONS - 1), .W(NIDX_W)) u_nidx (
        .clk(clk), .rst_n(rst_n), .en(nidx_inc), .clr(abort),
        .cnt(neuron_idx), .term(nidx_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Losing chip_sel outranks every other transition, including the final handshake.
    always_comb begin
        state_d = state_q;
        if (state_q != ST_IDLE && !chip_sel) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (chip_sel && wr_en)  state_d = ST_LOAD;
                ST_LOAD:    if (wr_en && wr_term)   state_d = ST_THRESH;
                ST_THRESH:  if (threshold_ready)    state_d = ST_COMPUTE;
                ST_COMPUTE: if (rd_term)            state_d = (ACC_PIPE == 0) ? ST_OUTPUT : ST_DRAIN;
                ST_DRAIN:   if (drain_term)         state_d = ST_OUTPUT;
                ST_OUTPUT:  if (out_ready)          state_d = nidx_term ? ST_IDLE : ST_THRESH;
                default:                            state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        abort      = (state_q != ST_IDLE) && !chip_sel;
        wr_inc     = (state_q == ST_LOAD) && wr_en && !abort;
        rd_inc     = (state_q == ST_COMPUTE) && !abort;
        drain_inc  = (state_q == ST_DRAIN) && !abort;
        nidx_inc   = (state_q == ST_OUTPUT) && out_ready && !abort;
        mul_mem_en = (state_q == ST_COMPUTE);
        ac_mem_en  = (state_q == ST_COMPUTE);
        out_valid  = (state_q == ST_OUTPUT);
        busy       = (state_q != ST_IDLE);
        done       = nidx_inc && nidx_term;
        // The start term is input-driven, so hold it off while reset is asserted.
        rst_mem    = (rst_n && (state_q == ST_IDLE) && chip_sel && wr_en) || nidx_inc;
    end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// tb/tb_neuron_seq_ctrl.sv - directed bench for neuron_seq_ctrl (64/4/2 and 5/3/0 configurations)
module tb_neuron_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    logic       a_chip_sel, a_wr_en, a_thr, a_out_ready;
    logic       a_rst_mem, a_mul, a_ac, a_out_valid, a_busy, a_done;
    logic [5:0] a_wr_ptr, a_rd_ptr;
    logic [1:0] a_nidx;

    logic       b_chip_sel, b_wr_en, b_thr, b_out_ready;
    logic       b_rst_mem, b_mul, b_ac, b_out_valid, b_busy, b_done;
    logic [2:0] b_wr_ptr, b_rd_ptr;
    logic [1:0] b_nidx;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    neuron_seq_ctrl #(.DEPTH(64), .N_NEURONS(4), .ACC_PIPE(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .chip_sel(a_chip_sel), .wr_en(a_wr_en),
        .threshold_ready(a_thr), .out_ready(a_out_ready), .rst_mem(a_rst_mem),
        .mul_mem_en(a_mul), .ac_mem_en(a_ac), .wr_data_ptr(a_wr_ptr),
        .rd_data_ptr(a_rd_ptr), .neuron_idx(a_nidx), .out_valid(a_out_valid),
        .busy(a_busy), .done(a_done)
    );

    neuron_seq_ctrl #(.DEPTH(5), .N_NEURONS(3), .ACC_PIPE(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .chip_sel(b_chip_sel), .wr_en(b_wr_en),
        .threshold_ready(b_thr), .out_ready(b_out_ready), .rst_mem(b_rst_mem),
        .mul_mem_en(b_mul), .ac_mem_en(b_ac), .wr_data_ptr(b_wr_ptr),
        .rd_data_ptr(b_rd_ptr), .neuron_idx(b_nidx), .out_valid(b_out_valid),
        .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_a_idle(input string tag);
        chk(tag, {a_busy, a_mul, a_ac, a_out_valid, a_done, a_rst_mem, a_wr_ptr, a_rd_ptr, a_nidx}, 32'd0);
    endtask

    task automatic load_a(input bit stall);
        a_chip_sel = 1'b1;
        a_wr_en    = 1'b1;
        #1 chk("a_start_rst_mem", a_rst_mem, 1'b1);
        tick();
        chk("a_load_busy", a_busy, 1'b1);
        chk("a_load_ptr0", a_wr_ptr, 0);
        for (int k = 0; k < 64; k++) begin
            if (stall && k < 6) begin
                a_wr_en = 1'b0;
                tick();
                chk("a_stall_ptr", a_wr_ptr, k);
                a_wr_en = 1'b1;
            end
            tick();
            chk("a_load_ptr", a_wr_ptr, (k + 1) % 64);
        end
        a_wr_en = 1'b0;
    endtask

    task automatic neuron_a(input int n, input int hold, input bit abort_at_out);
        tick();
        chk("a_thresh_wait", {a_busy, a_mul, a_out_valid}, 3'b100);
        a_thr = 1'b1;
        tick();
        a_thr = 1'b0;
        for (int c = 0; c < 64; c++) begin
            chk("a_compute_en", {a_mul, a_ac}, 2'b11);
            chk("a_rd_ptr", a_rd_ptr, c);
            chk("a_compute_idx", a_nidx, n);
            tick();
        end
        chk("a_drain1", {a_mul, a_ac, a_out_valid}, 3'b000);
        chk("a_drain_rd_wrap", a_rd_ptr, 0);
        tick();
        chk("a_drain2", {a_mul, a_ac, a_out_valid}, 3'b000);
        tick();
        chk("a_valid_at_67", a_out_valid, 1'b1);
        for (int h = 0; h < hold; h++) begin
            chk("a_bp_valid", a_out_valid, 1'b1);
            chk("a_bp_idx", a_nidx, n);
            chk("a_bp_quiet", {a_mul, a_ac, a_rst_mem, a_done}, 4'b0000);
            tick();
        end
        if (abort_at_out) begin
            a_chip_sel  = 1'b0;
            a_out_ready = 1'b1;
            #1 chk("a_abort_out_pulses", {a_done, a_rst_mem}, 2'b00);
            tick();
            a_out_ready = 1'b0;
            chk_a_idle("a_abort_out_idle");
        end else begin
            a_out_ready = 1'b1;
            #1 chk("a_hs_rst_mem", a_rst_mem, 1'b1);
            chk("a_hs_done", a_done, (n == 3));
            tick();
            a_out_ready = 1'b0;
            chk("a_next_idx", a_nidx, (n + 1) % 4);
            chk("a_after_busy", a_busy, (n != 3));
            chk("a_after_done", a_done, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_chip_sel = 0; a_wr_en = 0; a_thr = 0; a_out_ready = 0;
        b_chip_sel = 0; b_wr_en = 0; b_thr = 0; b_out_ready = 0;
        #3;
        chk_a_idle("a_reset");
        chk("b_reset", {b_busy, b_mul, b_ac, b_out_valid, b_done, b_rst_mem, b_wr_ptr, b_rd_ptr, b_nidx}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_a_idle("a_post_reset");

        // full run with load stall and backpressure on neuron 1
        load_a(1'b1);
        neuron_a(0, 0, 1'b0);
        neuron_a(1, 10, 1'b0);
        neuron_a(2, 0, 1'b0);
        neuron_a(3, 0, 1'b0);
        chk_a_idle("a_run_end");

        // abort during neuron 2 compute at rd_ptr 30
        load_a(1'b0);
        neuron_a(0, 0, 1'b0);
        neuron_a(1, 0, 1'b0);
        tick();
        a_thr = 1'b1;
        tick();
        a_thr = 1'b0;
        repeat (30) tick();
        chk("a_abort_rd30", a_rd_ptr, 30);
        chk("a_abort_idx2", a_nidx, 2);
        a_chip_sel = 1'b0;
        #1 chk("a_abort_pulses", {a_done, a_rst_mem}, 2'b00);
        tick();
        chk_a_idle("a_abort_idle");

        // abort colliding with the final handshake
        load_a(1'b0);
        neuron_a(0, 0, 1'b0);
        neuron_a(1, 0, 1'b0);
        neuron_a(2, 0, 1'b0);
        neuron_a(3, 3, 1'b1);

        // asynchronous reset in the middle of COMPUTE
        load_a(1'b0);
        tick();
        a_thr = 1'b1;
        tick();
        a_thr = 1'b0;
        repeat (10) tick();
        chk("a_pre_reset_rd", a_rd_ptr, 10);
        #1 rst_n = 1'b0;
        #1 chk_a_idle("a_async_reset");
        tick();
        chk_a_idle("a_held_reset");
        rst_n = 1'b1;
        a_chip_sel = 1'b0;
        tick();
        chk_a_idle("a_reset_release");

        // small configuration: DEPTH=5, N_NEURONS=3, ACC_PIPE=0
        b_chip_sel = 1'b1;
        b_wr_en    = 1'b1;
        #1 chk("b_start_rst_mem", b_rst_mem, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("b_load_ptr", b_wr_ptr, (k + 1) % 5);
        end
        b_wr_en = 1'b0;
        for (int n = 0; n < 3; n++) begin
            chk("b_thresh_wait", {b_busy, b_mul, b_out_valid}, 3'b100);
            b_thr = 1'b1;
            tick();
            b_thr = 1'b0;
            for (int c = 0; c < 5; c++) begin
                chk("b_compute_en", {b_mul, b_ac}, 2'b11);
                chk("b_rd_ptr", b_rd_ptr, c);
                chk("b_idx", b_nidx, n);
                tick();
            end
            chk("b_valid_no_drain", {b_out_valid, b_mul, b_ac}, 3'b100);
            chk("b_rd_wrap", b_rd_ptr, 0);
            b_out_ready = 1'b1;
            #1 chk("b_hs_rst_mem", b_rst_mem, 1'b1);
            chk("b_hs_done", b_done, (n == 2));
            tick();
            b_out_ready = 1'b0;
            chk("b_next_idx", b_nidx, (n + 1) % 3);
            chk("b_after_busy", b_busy, (n != 2));
        end
        chk("b_done_low", b_done, 1'b0);
        b_chip_sel = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
